// File: rtl/fifo_read_drain.sv
// Read-side drain controller for an asynchronous FIFO: synchronises EMPTY, issues one R_EN
// pulse per word, and hands captured words to the consumer through a 2-entry skid buffer.
module fifo_read_drain #(
    parameter int unsigned P_DATA_WIDTH   = 8,
    parameter int unsigned P_SYNC_STAGES  = 2,
    parameter int unsigned P_PULSE_CYCLES = 2,
    parameter int unsigned P_CNT_WIDTH    = 16
) (
    input  logic                    CLK,
    input  logic                    RST_n,
    input  logic                    DRAIN_EN,
    input  logic                    FIFO_EMPTY,
    input  logic [P_DATA_WIDTH-1:0] FIFO_DATA,
    output logic                    FIFO_R_EN,
    output logic [P_DATA_WIDTH-1:0] OUT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [P_CNT_WIDTH-1:0]  RD_COUNT,
    output logic                    BUSY
);

    typedef enum logic [1:0] {StIdle, StPulse, StHoldoff} state_e;

    localparam logic [2:0] PulseLast = 3'(P_PULSE_CYCLES - 1);
    localparam logic [2:0] HoldLast  = 3'(P_SYNC_STAGES);

    state_e                    state_q, state_d;
    logic [2:0]                tcnt_q, tcnt_d;
    logic                      r_en_q, r_en_d;
    logic [P_SYNC_STAGES-1:0]  sync_q;
    logic                      empty_s;
    logic                      start;
    logic                      capture;
    logic                      pop;
    logic [1:0]                skid_cnt_q, skid_cnt_d;
    logic [P_DATA_WIDTH-1:0]   head_q, head_d;
    logic [P_DATA_WIDTH-1:0]   tail_q, tail_d;
    logic [P_CNT_WIDTH-1:0]    rd_count_q, rd_count_d;

    // Reset to all ones so EMPTY reads as asserted until the real flag has propagated.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[P_SYNC_STAGES-2:0], FIFO_EMPTY};
        end
    end

    assign empty_s = sync_q[P_SYNC_STAGES-1];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state_q <= StIdle;
            tcnt_q  <= '0;
            r_en_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tcnt_q  <= tcnt_d;
            r_en_q  <= r_en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StPulse;
                    tcnt_d  = '0;
                end
            end
            StPulse: begin
                if (tcnt_q == PulseLast) begin
                    state_d = StHoldoff;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 3'd1;
                end
            end
            StHoldoff: begin
                // Gives the post-pop EMPTY time to traverse the synchroniser.
                if (tcnt_q == HoldLast) begin
                    state_d = StIdle;
                    tcnt_d  = '0;
                end else begin
                    tcnt_d = tcnt_q + 3'd1;
                end
            end
            default: begin
                state_d = StIdle;
                tcnt_d  = '0;
            end
        endcase
        r_en_d = (state_d == StPulse);
    end

    always_comb begin
        start     = DRAIN_EN && !empty_s && (skid_cnt_q != 2'd2);
        capture   = (state_q == StPulse) && (tcnt_q == PulseLast);
        BUSY      = (state_q != StIdle);
        FIFO_R_EN = r_en_q;
    end

    assign pop = (skid_cnt_q != 2'd0) && OUT_READY;

    always_comb begin
        head_d     = head_q;
        tail_d     = tail_q;
        skid_cnt_d = skid_cnt_q;
        rd_count_d = rd_count_q;
        case ({capture, pop})
            2'b10: begin
                if (skid_cnt_q == 2'd0) head_d = FIFO_DATA;
                else                    tail_d = FIFO_DATA;
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b01: begin
                if (skid_cnt_q == 2'd2) head_d = tail_q;
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop keeps the occupancy and the FIFO order.
                if (skid_cnt_q == 2'd1) begin
                    head_d = FIFO_DATA;
                end else begin
                    head_d = tail_q;
                    tail_d = FIFO_DATA;
                end
            end
            default: ;
        endcase
        if (pop) rd_count_d = rd_count_q + P_CNT_WIDTH'(1);
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            head_q     <= '0;
            tail_q     <= '0;
            skid_cnt_q <= '0;
            rd_count_q <= '0;
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            skid_cnt_q <= skid_cnt_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign OUT_DATA  = head_q;
    assign OUT_VALID = (skid_cnt_q != 2'd0);
    assign RD_COUNT  = rd_count_q;

endmodule
